sockit_cdc_arb: RTL and testbench

Round-robin burst arbiter that shares the input port of one `sockit_cdc` crossing among `N` requesters in the input clock domain. Each requester has its own req/grt/bus stream. The arbiter grants one owner at a time and forwards that owner's stream to the shared port. Ownership is held for a burst of up to `BL` transfers and is released early on an end-of-burst marker or when the owner idles.

---
 rtl/sockit_cdc_arb_if.sv | 27 ++
 rtl/sockit_cdc_arb.sv | 94 +++++++++
 tb/tb_sockit_cdc_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sockit_cdc_arb_if.sv
// Requester-side and shared-port signals of the sockit_cdc round-robin arbiter.
// The master modport is the environment; the slave modport is the arbiter.
interface sockit_cdc_arb_if #(
   parameter int N  = 4,
   parameter int IW = 2,
   parameter int DW = 8
);
   logic [N*DW-1:0] ffi_bus;
   logic [N-1:0]    ffi_req;
   logic [N-1:0]    ffi_lst;
   logic [N-1:0]    ffi_grt;
   logic [DW-1:0]   ffo_bus;
   logic            ffo_req;
   logic            ffo_grt;
   logic [IW-1:0]   ffo_sel;
   logic            arb_bsy;

   modport master (
      output ffi_bus, ffi_req, ffi_lst, ffo_grt,
      input  ffi_grt, ffo_bus, ffo_req, ffo_sel, arb_bsy
   );

   modport slave (
      input  ffi_bus, ffi_req, ffi_lst, ffo_grt,
      output ffi_grt, ffo_bus, ffo_req, ffo_sel, arb_bsy
   );
endinterface

// File: rtl/sockit_cdc_arb.sv
// Round-robin burst arbiter sharing one sockit_cdc input port among N requesters.
// Ownership lasts up to BL transfers, ending early on lst or when the owner idles.
module sockit_cdc_arb #(
   parameter int N  = 4,
   parameter int IW = 2,
   parameter int DW = 8,
   parameter int BL = 4
)(
   input  logic            ffi_clk,
   input  logic            ffi_rst,
   sockit_cdc_arb_if.slave arb
);
   localparam int          CW       = $clog2(BL + 1);
   localparam int unsigned NU       = N;
   localparam logic [CW-1:0] CNT_LAST = CW'(BL - 1);
   localparam logic [IW-1:0] OWN_LAST = IW'(N - 1);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t        r_state, w_state_nxt;
   logic [IW-1:0] r_own, w_own_nxt;
   logic [IW-1:0] r_ptr, w_ptr_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [IW-1:0] w_pick;
   logic          w_any;
   logic          w_xfer;
   logic          w_rel;

   // first requester at or after ptr, wrapping
   always_comb begin
      w_pick = '0;
      w_any  = 1'b0;
      for (int unsigned k = 0; k < NU; k++) begin
         if (!w_any && arb.ffi_req[(32'(r_ptr) + k) % NU]) begin
            w_any  = 1'b1;
            w_pick = IW'((32'(r_ptr) + k) % NU);
         end
      end
   end

   always_ff @(posedge ffi_clk or negedge ffi_rst) begin
      if (!ffi_rst) begin
         r_state <= S_IDLE;
         r_own   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_own   <= w_own_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_own_nxt   = r_own;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_xfer      = 1'b0;
      w_rel       = 1'b0;
      arb.ffo_req = 1'b0;
      arb.ffo_bus = '0;
      arb.ffi_grt = '0;
      arb.ffo_sel = '0;
      arb.arb_bsy = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_nxt = S_OWN;
               w_own_nxt   = w_pick;
               w_cnt_nxt   = '0;
            end
         end
         S_OWN: begin
            arb.ffo_req        = arb.ffi_req[r_own];
            arb.ffo_bus        = arb.ffi_bus[32'(r_own)*DW +: DW];
            arb.ffi_grt[r_own] = arb.ffo_grt;
            arb.ffo_sel        = r_own;
            arb.arb_bsy        = 1'b1;
            w_xfer = arb.ffi_req[r_own] & arb.ffo_grt;
            w_rel  = !arb.ffi_req[r_own] |
                     (w_xfer & (arb.ffi_lst[r_own] | (r_cnt == CNT_LAST)));
            if (w_xfer) w_cnt_nxt = r_cnt + CW'(1);
            if (w_rel) begin
               w_state_nxt = S_IDLE;
               w_ptr_nxt   = (r_own == OWN_LAST) ? '0 : r_own + IW'(1);
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_sockit_cdc_arb.sv
// Self-checking bench for sockit_cdc_arb: directed scenarios plus random traffic
// compared against a transaction-level arbitration model.
module tb_sockit_cdc_arb;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int DW = 8;
   localparam int BL = 4;

   typedef struct {
      int sel;
      int data;
   } obs_t;

   logic          clk;
   logic          rst_n;
   logic [DW-1:0] tb_bus [N];

   int   n_assert = 0;
   int   n_fail   = 0;
   bit   m_busy   = 1'b0;
   int   m_own    = 0;
   int   m_ptr    = 0;
   int   m_cnt    = 0;
   int   m_xfer   = -1;
   obs_t obs_q[$];

   sockit_cdc_arb_if #(.N(N), .IW(IW), .DW(DW)) arb ();

   sockit_cdc_arb #(.N(N), .IW(IW), .DW(DW), .BL(BL)) dut (
      .ffi_clk (clk),
      .ffi_rst (rst_n),
      .arb     (arb)
   );

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign arb.ffi_bus[g*DW +: DW] = tb_bus[g];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the model, log shared transfers,
   // then advance the model across the rising edge.
   task automatic step();
      logic [N-1:0] eg;
      bit nbusy;
      int no, np, nc;
      #1;
      if (!rst_n) begin
         m_busy = 1'b0; m_own = 0; m_ptr = 0; m_cnt = 0;
      end
      eg = '0;
      if (m_busy) eg[m_own] = arb.ffo_grt;
      chk("ffo_req", arb.ffo_req, m_busy ? arb.ffi_req[m_own] : 1'b0);
      chk("ffo_bus", arb.ffo_bus, m_busy ? tb_bus[m_own] : '0);
      chk("ffi_grt", arb.ffi_grt, eg);
      chk("ffo_sel", arb.ffo_sel, m_busy ? m_own : 0);
      chk("arb_bsy", arb.arb_bsy, m_busy);
      if (arb.ffo_req && arb.ffo_grt) obs_q.push_back('{int'(arb.ffo_sel), int'(arb.ffo_bus)});
      m_xfer = -1;
      nbusy = m_busy; no = m_own; np = m_ptr; nc = m_cnt;
      if (rst_n) begin
         if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
               if (!nbusy && arb.ffi_req[(m_ptr + k) % N]) begin
                  nbusy = 1'b1; no = (m_ptr + k) % N; nc = 0;
               end
            end
         end else begin
            if (arb.ffi_req[m_own] && arb.ffo_grt) begin
               m_xfer = m_own;
               nc = m_cnt + 1;
            end
            if (!arb.ffi_req[m_own] || (m_xfer >= 0 && (arb.ffi_lst[m_own] || nc == BL))) begin
               nbusy = 1'b0; np = (m_own + 1) % N; nc = 0;
            end
         end
      end
      @(posedge clk);
      if (rst_n) begin
         m_busy = nbusy; m_own = no; m_ptr = np; m_cnt = nc;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int data;
      int steps;
      bit pend [N];
      rst_n       = 1'b0;
      arb.ffi_req = '0;
      arb.ffi_lst = '0;
      arb.ffo_grt = 1'b1;
      for (int i = 0; i < N; i++) begin
         tb_bus[i] = DW'(8'h10 * (i + 1));
         pend[i]   = 1'b0;
      end

      // reset held with every requester asking, then round-robin
      arb.ffi_req = '1;
      repeat (3) step();
      rst_n = 1'b1;
      obs_q.delete();
      step();
      #1;
      chk("first_owner", arb.ffo_sel, 0);
      chk("first_bsy", arb.arb_bsy, 1);
      repeat (39) step();
      chk("rr_count", obs_q.size(), 32);
      for (int i = 0; i < obs_q.size() && i < 32; i++)
         chk("rr_owner", obs_q[i].sel, (i / BL) % N);

      // asynchronous reset in the middle of a burst
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      arb.ffi_req = '0;
      step();

      // single requester streaming 0..63
      do_reset();
      arb.ffi_req = 4'b0100;
      obs_q.delete();
      data = 0;
      steps = 0;
      while (data < 64 && steps < 200) begin
         tb_bus[2] = DW'(data);
         step();
         steps++;
         if (m_xfer == 2) data++;
      end
      arb.ffi_req = '0;
      chk("single_cycles", steps, 80);
      chk("single_count", obs_q.size(), 64);
      for (int i = 0; i < obs_q.size() && i < 64; i++) begin
         chk("single_sel", obs_q[i].sel, 2);
         chk("single_data", obs_q[i].data, i);
      end
      step();

      // early end: requester 1 marks lst on its second transfer
      do_reset();
      arb.ffi_req = 4'b1110;
      obs_q.delete();
      step();
      step();
      arb.ffi_lst = 4'b0010;
      step();
      arb.ffi_lst = '0;
      step();
      #1;
      chk("early_next_owner", arb.ffo_sel, 2);
      chk("early_count", obs_q.size(), 2);
      for (int i = 0; i < obs_q.size() && i < 2; i++)
         chk("early_sel", obs_q[i].sel, 1);
      arb.ffi_req = '0;
      step();
      step();

      // backpressure on requester 3 after one transfer
      do_reset();
      arb.ffi_req = 4'b1000;
      obs_q.delete();
      step();
      step();
      arb.ffi_req = 4'b1001;
      arb.ffo_grt = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_grt_low", arb.ffi_grt, 4'b0000);
         chk("bp_sel", arb.ffo_sel, 3);
      end
      chk("bp_held_count", obs_q.size(), 1);
      arb.ffo_grt = 1'b1;
      repeat (3) step();
      step();
      #1;
      chk("bp_next_owner", arb.ffo_sel, 0);
      chk("bp_count", obs_q.size(), 4);
      for (int i = 0; i < obs_q.size() && i < 4; i++)
         chk("bp_sel_log", obs_q[i].sel, 3);
      arb.ffi_req = '0;
      step();
      step();

      // owner goes idle after one transfer
      do_reset();
      arb.ffi_req = 4'b0001;
      step();
      step();
      arb.ffi_req = 4'b0000;
      step();
      #1;
      chk("idle_bsy", arb.arb_bsy, 0);
      arb.ffi_req = 4'b0011;
      step();
      #1;
      chk("idle_next_owner", arb.ffo_sel, 1);
      arb.ffi_req = '0;
      step();
      step();

      // random traffic with requesters honouring the hold-until-transfer rule
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]   = 1'b1;
               tb_bus[i] = DW'($urandom);
            end
            arb.ffi_req[i] = pend[i];
         end
         arb.ffi_lst = N'($urandom);
         arb.ffo_grt = ($urandom_range(0, 3) != 0);
         rst_n = (c != 1500);
         step();
         if (m_xfer >= 0) begin
            pend[m_xfer] = bit'($urandom_range(0, 1));
            tb_bus[m_xfer] = DW'($urandom);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
